// File: rtl/data_bus_arb.sv
// data_bus_arb: round-robin arbiter that merges NUM_SRC valid/ready sources
// into a FIFO_DEPTH-entry FIFO; the FIFO head drives one valid/ready sink.
// Each stored word carries the index of the source that produced it.
// Optional feature: define DATA_BUS_PARITY_EN to store the even parity of
// every word alongside it and expose the head's parity on bus_parity.
module data_bus_arb #(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_SRC    = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int ID_W       = $clog2(NUM_SRC),
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic                          bus_valid,
  output logic [DATA_WIDTH-1:0]         bus_data,
  output logic [ID_W-1:0]               bus_src_id,
`ifdef DATA_BUS_PARITY_EN
  output logic                          bus_parity,
`endif
  input  logic                          bus_ready,
  output logic [CNT_W-1:0]              fifo_count
);

  typedef struct packed {
`ifdef DATA_BUS_PARITY_EN
    logic                  parity;
`endif
    logic [ID_W-1:0]       id;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [ID_W-1:0]  LAST_SRC = ID_W'(NUM_SRC - 1);

  entry_t           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ID_W-1:0]  rr_q, rr_d;

  logic             grant_valid;
  logic [ID_W-1:0]  grant_idx;
  logic             push;
  logic             pop;
  entry_t           push_entry;
  entry_t           head;

  // Round-robin search from rr_q upward; no grant while full or in reset.
  always_comb begin
    logic [ID_W-1:0] cand;
    // NOTE: every variable driven here gets a default before any branch, so no path can leave it unassigned and infer a latch.
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (!rst && (count_q != FULL_CNT)) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        cand = ID_W'((int'(rr_q) + k) % NUM_SRC);
        if (!grant_valid && src_valid[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  assign src_ready = grant_valid ? (NUM_SRC'(1) << grant_idx) : '0;
  assign push      = grant_valid;
  assign pop       = bus_valid & bus_ready;

  // Build the entry to store: the granted source's word, its index and parity.
  always_comb begin
    push_entry    = '0;
    push_entry.id = grant_idx;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (grant_idx == ID_W'(s)) begin
        push_entry.data = src_data[s*DATA_WIDTH +: DATA_WIDTH];
      end
    end
`ifdef DATA_BUS_PARITY_EN
    push_entry.parity = ^push_entry.data;
`endif
  end

  // Next-state for pointers, occupancy and the round-robin pointer.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so each statement sees the values assigned above it; clocked state uses '<=' only.
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    rr_d    = rr_q;
    if (push) begin
      wr_d = wr_q + PTR_W'(1);
      rr_d = (grant_idx == LAST_SRC) ? '0 : grant_idx + ID_W'(1);
    end
    if (pop) begin
      rd_d = rd_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Control state: asynchronously cleared, updated on the rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      rr_q    <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      rr_q    <= rr_d;
    end
  end

  // FIFO storage write on every accepted push.
  // NOTE: the storage array has no reset; count_q and the pointers define which entries are live, and the output mux zeroes the bus when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= push_entry;
    end
  end

  assign head       = mem_q[rd_q];
  assign bus_valid  = (count_q != '0);
  assign bus_data   = bus_valid ? head.data : '0;
  assign bus_src_id = bus_valid ? head.id   : '0;
`ifdef DATA_BUS_PARITY_EN
  assign bus_parity = bus_valid ? head.parity : 1'b0;
`endif
  assign fifo_count = count_q;

endmodule

// File: tb/tb_data_bus_arb.sv
// tb_data_bus_arb: directed scenarios plus randomized traffic for
// data_bus_arb, checked every cycle against a queue-based reference model.
// Build with DATA_BUS_PARITY_EN defined to also cover bus_parity.
module tb_data_bus_arb;
  localparam int DW  = 8;
  localparam int NS  = 4;
  localparam int FD  = 4;
  localparam int IDW = 2;
  localparam int CW  = 3;
  localparam int SDW = NS * DW;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS-1:0]   src_valid;
  logic [SDW-1:0]  src_data;
  logic [NS-1:0]   src_ready;
  logic            bus_valid;
  logic [DW-1:0]   bus_data;
  logic [IDW-1:0]  bus_src_id;
  logic            bus_ready;
  logic [CW-1:0]   fifo_count;
`ifdef DATA_BUS_PARITY_EN
  logic            bus_parity;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int id;
    int data;
  } ent_t;

  ent_t model_q[$];
  ent_t sink_log[$];
  int   rr = 0;

  data_bus_arb #(.DATA_WIDTH(DW), .NUM_SRC(NS), .FIFO_DEPTH(FD)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .bus_valid  (bus_valid),
    .bus_data   (bus_data),
    .bus_src_id (bus_src_id),
`ifdef DATA_BUS_PARITY_EN
    .bus_parity (bus_parity),
`endif
    .bus_ready  (bus_ready),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, arbitration as a search from rr.
  always @(negedge clk) begin
    int            g;
    logic [NS-1:0] er;
    ent_t          h;
    if (rst) begin
      model_q.delete();
      rr = 0;
      check("rst_count", 32'(fifo_count), 0);
      check("rst_valid", 32'(bus_valid), 0);
      check("rst_data", 32'(bus_data), 0);
      check("rst_id", 32'(bus_src_id), 0);
      check("rst_ready", 32'(src_ready), 0);
    end else begin
      g = -1;
      if (model_q.size() < FD) begin
        for (int k = 0; k < NS; k++) begin
          if (g < 0 && ((src_valid >> ((rr + k) % NS)) & NS'(1)) != '0) g = (rr + k) % NS;
        end
      end
      er = '0;
      if (g >= 0) er = NS'(1) << g;
      h = '{0, 0};
      if (model_q.size() != 0) h = model_q[0];
      check("src_ready", 32'(src_ready), 32'(er));
      check("bus_valid", 32'(bus_valid), 32'(model_q.size() != 0));
      check("bus_data", 32'(bus_data), h.data);
      check("bus_src_id", 32'(bus_src_id), h.id);
      check("fifo_count", 32'(fifo_count), model_q.size());
`ifdef DATA_BUS_PARITY_EN
      check("bus_parity", 32'(bus_parity), 32'(^(DW'(h.data))));
`endif
      if (model_q.size() != 0 && bus_ready) begin
        sink_log.push_back(h);
        void'(model_q.pop_front());
      end
      if (g >= 0) begin
        model_q.push_back('{g, int'(DW'(src_data >> (g * DW)))});
        rr = (g + 1) % NS;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic v, input logic [DW-1:0] d);
    logic [SDW-1:0] m;
    m = SDW'({DW{1'b1}}) << (s * DW);
    src_valid = v ? (src_valid | (NS'(1) << s)) : (src_valid & ~(NS'(1) << s));
    src_data  = (src_data & ~m) | (SDW'(d) << (s * DW));
  endtask

  // Present one word on source s and hold it until accepted (bounded).
  task automatic send(input int s, input logic [DW-1:0] d, input bit rand_rdy);
    bit done;
    done = 1'b0;
    set_src(s, 1'b1, d);
    for (int n = 0; n < 100 && !done; n++) begin
      if (rand_rdy) bus_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      done = (src_ready & (NS'(1) << s)) != '0;
      @(posedge clk);
      #1;
    end
    set_src(s, 1'b0, d);
    check("send_accepted", 32'(done), 1);
  endtask

  initial begin
    rst       = 1'b1;
    src_valid = '0;
    src_data  = '0;
    bus_ready = 1'b0;

    // Requests during reset are never accepted.
    set_src(0, 1'b1, 8'h11);
    tick();
    #1;
    check("rst_hold_ready", 32'(src_ready), 0);
    check("rst_hold_count", 32'(fifo_count), 0);
    set_src(0, 1'b0, 8'h00);
    tick();
    rst = 1'b0;

    // Reset mid-stream with three words stored.
    send(0, 8'h10, 1'b0);
    send(1, 8'h20, 1'b0);
    send(2, 8'h21, 1'b0);
    #1;
    check("mid_count3", 32'(fifo_count), 3);
    check("mid_head", 32'(bus_data), 32'h10);
    set_src(0, 1'b1, 8'h11);
    set_src(1, 1'b1, 8'h55);
    set_src(2, 1'b1, 8'h55);
    set_src(3, 1'b1, 8'h55);
    #1;
    rst = 1'b1;
    #1;
    check("async_count", 32'(fifo_count), 0);
    check("async_valid", 32'(bus_valid), 0);
    check("async_data", 32'(bus_data), 0);
    check("async_ready", 32'(src_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_grant", 32'(src_ready), 32'h1);
    tick();
    src_valid = '0;
    check("post_rst_valid", 32'(bus_valid), 1);
    check("post_rst_data", 32'(bus_data), 32'h11);
    check("post_rst_id", 32'(bus_src_id), 0);
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    #1;
    check("post_rst_drain", 32'(fifo_count), 0);

    // Fairness: every source always requesting, sink always ready.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NS; i++) set_src(i, 1'b1, 8'(8'hA0 + i));
    bus_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("fair_grant", 32'(src_ready), 1 << (k % 4));
      tick();
      check("fair_id", 32'(bus_src_id), k % 4);
      check("fair_data", 32'(bus_data), 32'hA0 + (k % 4));
      check("fair_count", 32'(fifo_count), 1);
    end
    src_valid = '0;
    tick();
    #1;
    check("fair_drain", 32'(fifo_count), 0);

    // Full / backpressure.
    bus_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_src(1, 1'b1, 8'(k + 1));
      #1;
      check("full_grant", 32'(src_ready), 32'h2);
      tick();
    end
    set_src(1, 1'b1, 8'h05);
    #1;
    check("full_count", 32'(fifo_count), 4);
    check("full_ready", 32'(src_ready), 0);
    check("full_head", 32'(bus_data), 32'h01);
    bus_ready = 1'b1;
    #1;
    check("full_pop_ready", 32'(src_ready), 0);
    check("full_pop_count", 32'(fifo_count), 4);
    tick();
    bus_ready = 1'b0;
    #1;
    check("after_pop_count", 32'(fifo_count), 3);
    check("after_pop_head", 32'(bus_data), 32'h02);
    check("after_pop_grant", 32'(src_ready), 32'h2);
    tick();
    set_src(1, 1'b0, 8'h00);
    check("fifth_count", 32'(fifo_count), 4);
    bus_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("full_order", 32'(bus_data), 32'(k + 2));
      tick();
    end
    check("full_drain", 32'(fifo_count), 0);

    // Simultaneous push and pop at occupancy 2.
    bus_ready = 1'b0;
    send(3, 8'h50, 1'b0);
    send(3, 8'h51, 1'b0);
    #1;
    check("pp_count_pre", 32'(fifo_count), 2);
    set_src(3, 1'b1, 8'h52);
    bus_ready = 1'b1;
    #1;
    check("pp_grant", 32'(src_ready), 32'h8);
    tick();
    set_src(3, 1'b0, 8'h00);
    #1;
    check("pp_count", 32'(fifo_count), 2);
    check("pp_head", 32'(bus_data), 32'h51);
    check("pp_id", 32'(bus_src_id), 3);
    tick();
    #1;
    check("pp_head2", 32'(bus_data), 32'h52);
    check("pp_count2", 32'(fifo_count), 1);
    tick();
    bus_ready = 1'b0;
    #1;
    check("pp_drain", 32'(fifo_count), 0);

    // Pointer wrap: ten words through source 2 with random sink readiness.
    sink_log.delete();
    for (int i = 0; i < 10; i++) send(2, 8'(8'h30 + i), 1'b1);
    bus_ready = 1'b1;
    for (int n = 0; n < 20 && fifo_count != '0; n++) tick();
    bus_ready = 1'b0;
    tick();
    check("wrap_total", sink_log.size(), 10);
    for (int i = 0; i < 10 && i < sink_log.size(); i++) begin
      check("wrap_id", sink_log[i].id, 2);
      check("wrap_data", sink_log[i].data, 32'h30 + i);
    end

`ifdef DATA_BUS_PARITY_EN
    // Parity travels with its word.
    send(0, 8'h07, 1'b0);
    send(0, 8'h03, 1'b0);
    #1;
    check("par_head07", 32'(bus_data), 32'h07);
    check("par_07", 32'(bus_parity), 1);
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    #1;
    check("par_head03", 32'(bus_data), 32'h03);
    check("par_03", 32'(bus_parity), 0);
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
`endif

    // Randomized traffic with one reset pulse in the middle.
    for (int c = 0; c < 400; c++) begin
      src_valid = NS'($urandom);
      src_data  = SDW'($urandom);
      bus_ready = ($urandom_range(0, 3) != 0);
      rst       = (c == 200);
      tick();
    end
    rst       = 1'b0;
    src_valid = '0;
    bus_ready = 1'b1;
    for (int n = 0; n < 6; n++) tick();
    check("final_empty", 32'(fifo_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
